fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch unit with a prefetch queue. It owns the program counter and issues sequential reads to the synchronous instruction memory. Fetched words are buffered in a DEPTH-entry FIFO and handed to the decode stage over a valid/ready handshake. A jump redirects the PC, flushes the queue and discards any read still in flight. It replaces the bare program-counter-plus-ALU increment path between the PC and memory.

## Interface
Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 16, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- PC_STEP, 2, PC increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  read address; always equals fetch_pc.
- mem_rd  out  1  read request this cycle.
- mem_data  in  DATA_W  read data, valid the cycle after mem_rd (1-cycle synchronous memory).
- jump_en  in  1  redirect request this cycle.
- jump_addr  in  ADDR_W  redirect target.
- instr_valid  out  1  FIFO head holds an instruction.
- instr_ready  in  1  consumer accepts the head this cycle.
- instr  out  DATA_W  FIFO head instruction word.
- instr_pc  out  ADDR_W  address the head word was fetched from.
- fetch_pc  out  ADDR_W  next address to fetch.

## Operation
- State: fetch_pc; FIFO of {instr, pc} pairs; count (0..DEPTH); inflight flag with its captured address; kill flag.
- Pop: occurs when instr_valid && instr_ready && !jump_en.
- Issue: mem_rd = !jump_en && (count + inflight − pop < DEPTH), evaluated combinationally.
- On issue: inflight is set with the address fetch_pc, and fetch_pc advances by PC_STEP modulo 2^ADDR_W. The wrap from 0xFFFE to 0x0000 (defaults) is silent.
- Response: on the cycle after an issue, mem_data and the captured address are pushed into the FIFO, unless kill is set. Inflight then clears.
- Jump, when jump_en=1:
  - fetch_pc is set to jump_addr and the FIFO is emptied (count=0).
  - Any response arriving next cycle is marked kill and dropped.
  - mem_rd is 0 in the jump cycle. instr_ready in the jump cycle has no effect and the head is not consumed.
- Jump during the response cycle: the response is dropped and the flush still applies.
- Back-to-back jumps: the last jump wins, and no fetch is issued until the first cycle with jump_en=0.
- FIFO full (count=DEPTH): no issue, and fetch_pc holds.
- FIFO empty: instr_valid=0, and instr/instr_pc hold their last value (don't-care).
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- Reset mid-operation: all state returns to reset values immediately. The in-flight response after reset release is never pushed, because inflight is cleared.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, mem_addr = RESET_PC.
  - mem_rd = 0 while reset is asserted.
  - instr_valid = 0, count = 0, inflight = 0, kill = 0.
  - instr = 0 and instr_pc = 0.
- First cycle after reset release: mem_rd=1 with mem_addr=RESET_PC.
- Fetch-to-decode latency: mem_rd in cycle N gives mem_data in N+1, which is pushed at the end of N+1, so instr_valid=1 in N+2.
- Jump in cycle J: the first fetch of jump_addr is in J+1, and the first valid target instruction is in J+3. instr_valid=0 in J+1 and J+2.
- Throughput: one instruction per cycle sustained when instr_ready is held high (DEPTH≥2).
- Backpressure: with instr_ready=0 the FIFO fills to DEPTH. After that mem_rd=0 and fetch_pc holds until a pop.

## Test plan
- Reset/stream: the bench memory returns addr+0x100. Release reset with instr_ready=1. Required: mem_addr is 0,2,4,6 on consecutive cycles; instr is 0x100,0x102,0x104,0x106 with instr_pc 0,2,4,6; the first instr_valid is 2 cycles after reset release.
- Backpressure: instr_ready=0 for 10 cycles. Required: count reaches 4 and mem_rd drops after 4 fetches (addresses 0..6); fetch_pc=8 holds. On release, the next fetch is 8 and no word is lost or duplicated.
- Jump flush: jump_en=1 with jump_addr=0x40 while the FIFO holds 3 entries and a read is in flight. Required: instr_valid=0 for two cycles, then instr=0x140 with instr_pc=0x40; no stale word appears.
- Jump with pop: jump_en=1 and instr_ready=1 in the same cycle. Required: the head is not counted as consumed, and the next delivered word is from jump_addr.
- Wrap: jump to 0xFFFC. Required: the fetch sequence is 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- Reset mid-fetch: assert reset with inflight=1 and count=2. Required: outputs return to reset values asynchronously, and after release the first delivered word is from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues sequential reads to a 1-cycle
// synchronous memory and buffers {instr, pc} pairs in a prefetch FIFO.
module fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter int                 PC_STEP  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              kill;

    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;

    assign pop  = instr_valid && instr_ready && !jump_en;
    // A response landing in a jump cycle, or right after one, belongs to the old stream.
    assign push = inflight && !kill && !jump_en;

    // Slots already committed: stored words plus the read whose data arrives this cycle.
    always_comb begin
        occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    end

    // Gated by reset so no read is requested while reset is held.
    assign mem_rd      = reset && !jump_en && (occupancy < DEPTH_OCC);
    assign mem_addr    = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            kill          <= 1'b0;
        end else begin
            kill     <= jump_en;
            inflight <= mem_rd;
            if (mem_rd) begin
                inflight_addr <= fetch_pc;
            end
            if (jump_en) begin
                fetch_pc <= jump_addr;
            end else if (mem_rd) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (jump_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Issue throttling guarantees a free slot whenever a push happens.
            if (push) begin
                fifo_data[wr_ptr] <= mem_data;
                fifo_pc[wr_ptr]   <= inflight_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
